// File: rtl/bf_weight_loader_if.sv
// Weight write port and commit controls for the beamformer weight loader.
// The master drives writes and commit/frame pulses; the slave returns wr_ready.
interface bf_weight_loader_if #(
  parameter int WW = 5
);
  // A write transfers on a rising clock edge where wr_valid and wr_ready are
  // both high; wr_addr/wr_bcast/wr_data are sampled only on that edge and the
  // master holds them stable while wr_valid is high and wr_ready is low.
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_addr;
  logic          wr_bcast;
  logic [WW-1:0] wr_data;
  logic          commit_req;
  logic          frame_strobe;

  modport master (
    output wr_valid, wr_addr, wr_bcast, wr_data, commit_req, frame_strobe,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_bcast, wr_data, commit_req, frame_strobe,
    output wr_ready
  );
endinterface

// File: rtl/bf_weight_loader.sv
// Shadow/active weight banks for the 8-channel beamformer. Writes land in the
// shadow bank; a requested commit copies it to the active bank on a frame strobe.
module bf_weight_loader #(
  parameter int NCH = 8,
  parameter int WW  = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  bf_weight_loader_if.slave       wr,
  output logic [NCH-1:0][WW-1:0]  w_cos_1,
  output logic [NCH-1:0][WW-1:0]  w_sin_1,
  output logic [NCH-1:0][WW-1:0]  w_cos_2,
  output logic [NCH-1:0][WW-1:0]  w_sin_2,
  output logic                    commit_pending,
  output logic                    commit_done,
  output logic                    dirty,
  output logic                    weights_valid,
  output logic                    dbg_state
);

  typedef enum logic {S_IDLE, S_ARMED} state_t;

  typedef logic [NCH-1:0][3:0][WW-1:0] bank_t;

  state_t state_q, state_d;
  bank_t  shadow_q, shadow_d;
  bank_t  active_q, active_d;
  logic   dirty_q, dirty_d;
  logic   valid_q, valid_d;
  logic   done_q, done_d;
  logic   wr_fire;
  logic   commit;

  assign wr.wr_ready = (state_q == S_IDLE);
  assign wr_fire     = wr.wr_valid && wr.wr_ready;

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr.commit_req) state_d = S_ARMED;
      end
      S_ARMED: begin
        // A strobe in the same cycle as the request is already past; only a
        // strobe seen while armed performs the copy.
        if (wr.frame_strobe) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    valid_d  = valid_q | commit;
    done_d   = commit;
    if (wr_fire) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (wr.wr_bcast || (3'(ch) == wr.wr_addr[4:2])) begin
          shadow_d[ch][wr.wr_addr[1:0]] = wr.wr_data;
        end
      end
      dirty_d = 1'b1;
    end
    if (commit) begin
      active_d = shadow_q;
      dirty_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      active_q <= '0;
      dirty_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      w_cos_1[ch] = active_q[ch][0];
      w_sin_1[ch] = active_q[ch][1];
      w_cos_2[ch] = active_q[ch][2];
      w_sin_2[ch] = active_q[ch][3];
    end
  end

  assign commit_pending = (state_q == S_ARMED);
  assign commit_done    = done_q;
  assign dirty          = dirty_q;
  assign weights_valid  = valid_q;
  assign dbg_state      = (state_q == S_ARMED);

endmodule

// File: tb/tb_bf_weight_loader.sv
// Bench for bf_weight_loader: directed scenarios plus random traffic, checked
// every cycle against a bank-level model of the shadow/active weights.
module tb_bf_weight_loader;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0][4:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
  logic commit_pending, commit_done, dirty, weights_valid, dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  bf_weight_loader_if #(.WW(5)) bus ();

  bf_weight_loader #(.NCH(8), .WW(5)) dut (
    .clock          (clk),
    .reset          (rst_n),
    .wr             (bus),
    .w_cos_1        (w_cos_1),
    .w_sin_1        (w_sin_1),
    .w_cos_2        (w_cos_2),
    .w_sin_2        (w_sin_2),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .dirty          (dirty),
    .weights_valid  (weights_valid),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model: two weight arrays plus flags
  logic [4:0] m_shadow [8][4];
  logic [4:0] m_active [8][4];
  bit m_pending = 0, m_dirty = 0, m_valid = 0, m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 8; c++)
        for (int s = 0; s < 4; s++) begin
          m_shadow[c][s] = '0;
          m_active[c][s] = '0;
        end
      m_pending = 0; m_dirty = 0; m_valid = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_pending) begin
        if (bus.wr_valid) begin
          for (int c = 0; c < 8; c++)
            if (bus.wr_bcast || c == int'(bus.wr_addr[4:2]))
              m_shadow[c][bus.wr_addr[1:0]] = bus.wr_data;
          m_dirty = 1;
        end
        if (bus.commit_req) m_pending = 1;
      end else if (bus.frame_strobe) begin
        m_active  = m_shadow;
        m_dirty   = 0;
        m_valid   = 1;
        m_done    = 1;
        m_pending = 0;
      end
    end
  end

  function automatic logic [39:0] exp_vec(int s);
    logic [39:0] v;
    for (int c = 0; c < 8; c++) v[c*5 +: 5] = m_active[c][s];
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin
    chk("w_cos_1", 64'(w_cos_1), 64'(exp_vec(0)));
    chk("w_sin_1", 64'(w_sin_1), 64'(exp_vec(1)));
    chk("w_cos_2", 64'(w_cos_2), 64'(exp_vec(2)));
    chk("w_sin_2", 64'(w_sin_2), 64'(exp_vec(3)));
    chk("wr_ready", 64'(bus.wr_ready), 64'(!m_pending));
    chk("commit_pending", 64'(commit_pending), 64'(m_pending));
    chk("commit_done", 64'(commit_done), 64'(m_done));
    chk("dirty", 64'(dirty), 64'(m_dirty));
    chk("weights_valid", 64'(weights_valid), 64'(m_valid));
    if (commit_done === 1'b1) done_cnt++;
  end

  // driver tasks: inputs change just after the falling edge
  task automatic drive(bit v, logic [4:0] a, bit b, logic [4:0] d, bit cr, bit fs);
    bus.wr_valid     = v;
    bus.wr_addr      = a;
    bus.wr_bcast     = b;
    bus.wr_data      = d;
    bus.commit_req   = cr;
    bus.frame_strobe = fs;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 5'd0, 0, 5'd0, 0, 0);
  endtask

  task automatic commit_with_strobe();
    drive(0, 5'd0, 0, 5'd0, 1, 0);
    drive(0, 5'd0, 0, 5'd0, 0, 1);
  endtask

  int base;

  initial begin
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_bcast = 0; bus.wr_data = '0;
    bus.commit_req = 0; bus.frame_strobe = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // idle after reset
    idle(10);
    chk("lit_reset_cos2", 64'(w_cos_2), 64'd0);
    chk("lit_reset_valid", 64'(weights_valid), 64'd0);
    chk("lit_reset_done_cnt", 64'(done_cnt), 64'd0);

    // single write, commit with strobe 3 cycles later
    drive(1, 5'b011_10, 0, 5'h13, 0, 0);
    chk("lit_dirty_after_wr", 64'(dirty), 64'd1);
    chk("lit_cos2_unchanged", 64'(w_cos_2), 64'd0);
    drive(0, 5'd0, 0, 5'd0, 1, 0);
    idle(2);
    drive(0, 5'd0, 0, 5'd0, 0, 1);
    chk("lit_cos2_ch3", 64'(w_cos_2[3]), 64'h13);
    chk("lit_cos2_all", 64'(w_cos_2), 64'(40'h13) << 15);
    chk("lit_done_pulse", 64'(commit_done), 64'd1);
    idle(2);
    chk("lit_done_cnt1", 64'(done_cnt), 64'd1);
    chk("lit_valid_set", 64'(weights_valid), 64'd1);

    // broadcast sin_1
    drive(1, 5'b000_01, 1, 5'h1F, 0, 0);
    commit_with_strobe();
    chk("lit_bcast_sin1", 64'(w_sin_1), 64'({8{5'h1F}}));
    chk("lit_bcast_cos2_kept", 64'(w_cos_2[3]), 64'h13);

    // write coincident with commit_req, then blocked write while armed
    drive(1, 5'b111_11, 0, 5'h0A, 1, 0);
    drive(1, 5'b000_00, 0, 5'h07, 0, 0);
    chk("lit_ready_armed", 64'(bus.wr_ready), 64'd0);
    drive(0, 5'd0, 0, 5'd0, 0, 1);
    chk("lit_sin2_ch7", 64'(w_sin_2[7]), 64'h0A);
    chk("lit_cos1_ch0_blocked", 64'(w_cos_1[0]), 64'd0);

    // commit_req with strobe, then second request while armed
    base = done_cnt;
    drive(1, 5'b010_00, 0, 5'h05, 0, 0);
    drive(0, 5'd0, 0, 5'd0, 1, 1);
    chk("lit_no_commit_same", 64'(w_cos_1[2]), 64'd0);
    chk("lit_pending_same", 64'(commit_pending), 64'd1);
    drive(0, 5'd0, 0, 5'd0, 1, 0);
    drive(0, 5'd0, 0, 5'd0, 0, 1);
    chk("lit_cos1_ch2", 64'(w_cos_1[2]), 64'h05);
    idle(3);
    chk("lit_one_done", 64'(done_cnt - base), 64'd1);

    // reset while armed
    drive(1, 5'b001_00, 0, 5'h09, 0, 0);
    drive(0, 5'd0, 0, 5'd0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_pending", 64'(commit_pending), 64'd0);
    chk("lit_rst_sin1", 64'(w_sin_1), 64'd0);
    chk("lit_rst_valid", 64'(weights_valid), 64'd0);
    chk("lit_rst_ready", 64'(bus.wr_ready), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    base = done_cnt;
    drive(0, 5'd0, 0, 5'd0, 0, 1);
    idle(2);
    chk("lit_rst_no_commit", 64'(done_cnt - base), 64'd0);
    chk("lit_rst_cos1_zero", 64'(w_cos_1), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
            $urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
